// File: rtl/fact_accel.sv
// fact_accel: memory-mapped iterative factorial unit, one multiply step per clock.
// Define FACT_ACCEL_IRQ_EN to add the irq output and the status irq_pending bit.
module fact_accel #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 4,
  parameter int MAX_N   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [1:0]       a,
  input  logic [WIDTH-1:0] wd,
`ifdef FACT_ACCEL_IRQ_EN
  output logic             irq,
`endif
  output logic [WIDTH-1:0] rd
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [1:0] A_N   = 2'b00;
  localparam logic [1:0] A_GO  = 2'b01;
  localparam logic [1:0] A_ST  = 2'b10;
  localparam logic [1:0] A_RES = 2'b11;

  localparam logic [N_WIDTH-1:0] MAX_N_W = N_WIDTH'(MAX_N);
  localparam logic [N_WIDTH-1:0] ONE_N   = N_WIDTH'(1);
  localparam int                 PW      = WIDTH + N_WIDTH;

  state_t             state;
  state_t             state_nxt;
  logic [N_WIDTH-1:0] n_reg;
  logic [N_WIDTH-1:0] n_nxt;
  logic [N_WIDTH-1:0] cnt;
  logic [N_WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   result_nxt;
  logic               done;
  logic               done_nxt;
  logic               err;
  logic               err_nxt;
  logic               busy;
  logic               wr_n;
  logic               wr_go;
  logic               set_done;
  logic [PW-1:0]      prod;
  logic [WIDTH-1:0]   status;
  logic               unused_ok;

  assign busy  = (state == BUSY);
  assign wr_n  = we && (a == A_N) && !busy;
  assign wr_go = we && (a == A_GO) && wd[0] && !busy;

  // Narrow multiplier: cnt never exceeds N_WIDTH bits.
  assign prod = {{N_WIDTH{1'b0}}, result}
              * {{WIDTH{1'b0}}, cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      n_reg  <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      n_reg  <= n_nxt;
      cnt    <= cnt_nxt;
      result <= result_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    n_nxt      = n_reg;
    cnt_nxt    = cnt;
    result_nxt = result;
    done_nxt   = done;
    err_nxt    = err;
    set_done   = 1'b0;
    if (wr_n) begin
      n_nxt = wd[N_WIDTH-1:0];
    end
    unique case (state)
      IDLE, DONE: begin
        if (wr_go) begin
          done_nxt = 1'b0;
          err_nxt  = 1'b0;
          if (n_reg > MAX_N_W) begin
            err_nxt    = 1'b1;
            done_nxt   = 1'b1;
            set_done   = 1'b1;
            result_nxt = '0;
            state_nxt  = DONE;
          end else begin
            result_nxt = WIDTH'(1);
            cnt_nxt    = n_reg;
            state_nxt  = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt <= ONE_N) begin
          done_nxt  = 1'b1;
          set_done  = 1'b1;
          state_nxt = DONE;
        end else begin
          result_nxt = prod[WIDTH-1:0];
          cnt_nxt    = cnt - ONE_N;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef FACT_ACCEL_IRQ_EN
  logic irq_q;
  logic irq_pend;
  logic wr_st;

  assign wr_st = we && (a == A_ST);
  assign irq   = irq_q;

  // A new completion wins over a same-cycle acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q    <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      irq_q <= set_done;
      if (set_done) begin
        irq_pend <= 1'b1;
      end else if (wr_st) begin
        irq_pend <= 1'b0;
      end
    end
  end

  assign unused_ok = ^{wd[WIDTH-1:N_WIDTH], prod[PW-1:WIDTH]};
`else
  assign unused_ok = ^{wd[WIDTH-1:N_WIDTH], prod[PW-1:WIDTH], set_done};
`endif

  always_comb begin
    status    = '0;
    status[0] = done;
    status[1] = err;
    status[2] = busy;
`ifdef FACT_ACCEL_IRQ_EN
    status[3] = irq_pend;
`endif
  end

  always_comb begin
    rd = '0;
    unique case (a)
      A_N:     rd = {{(WIDTH-N_WIDTH){1'b0}}, n_reg};
      A_GO:    rd = '0;
      A_ST:    rd = status;
      A_RES:   rd = result;
      default: rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// tb_fact_accel: directed bus-vector bench for fact_accel.
// Build with FACT_ACCEL_IRQ_EN to also exercise the irq output.
module tb_fact_accel;

  localparam int W = 32;

  localparam logic [1:0] A_N  = 2'b00;
  localparam logic [1:0] A_G  = 2'b01;
  localparam logic [1:0] A_S  = 2'b10;
  localparam logic [1:0] A_R  = 2'b11;

  localparam logic [W-1:0] S_BUSY = 32'h4;
  localparam logic [W-1:0] S_DONE = 32'h1;
  localparam logic [W-1:0] S_ERR  = 32'h3;

  typedef struct {
    logic         we;
    logic [1:0]   a;
    logic [W-1:0] wd;
    logic         chk;
    logic [W-1:0] exp;
    string        tag;
  } vec_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         we    = 1'b0;
  logic [1:0]   a     = 2'b00;
  logic [W-1:0] wd    = '0;
  logic [W-1:0] rd;
`ifdef FACT_ACCEL_IRQ_EN
  logic         irq;
`endif

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  fact_accel #(
    .WIDTH  (32),
    .N_WIDTH(4),
    .MAX_N  (12)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .a    (a),
    .wd   (wd),
`ifdef FACT_ACCEL_IRQ_EN
    .irq  (irq),
`endif
    .rd   (rd)
  );

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  // Status bit 3 belongs to the irq checks; mask it elsewhere.
  task automatic check_rd(input string name,
                          input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = rd;
`ifdef FACT_ACCEL_IRQ_EN
    if (a == A_S) act[3] = 1'b0;
`endif
    check(name, act, exp);
  endtask

  task automatic step(input logic w,
                      input logic [1:0] ad,
                      input logic [W-1:0] d);
    @(negedge clk);
    we = w;
    a  = ad;
    wd = d;
    #1;
  endtask

  task automatic add(input logic w,
                     input logic [1:0] ad,
                     input logic [W-1:0] d,
                     input logic c,
                     input logic [W-1:0] e,
                     input string t);
    vec_t v;
    v.we  = w;
    v.a   = ad;
    v.wd  = d;
    v.chk = c;
    v.exp = e;
    v.tag = t;
    tbl.push_back(v);
  endtask

  task automatic add_busy(input int k, input string t);
    for (int i = 0; i < k; i++) add(0, A_S, 0, 1, S_BUSY, t);
  endtask

  task automatic run_poll(input logic [3:0] n,
                          input int exp_lat,
                          input logic [W-1:0] exp_res,
                          input string tag);
    int lat;
    lat = -1;
    step(1, A_N, W'(n));
    step(1, A_G, 1);
    for (int i = 1; i <= 64 && lat < 0; i++) begin
      step(0, A_S, 0);
      if (rd[0] === 1'b1) lat = i - 1;
    end
    check({tag, "_latency"}, W'(lat), W'(exp_lat));
    check_rd({tag, "_status"}, S_DONE);
    step(0, A_R, 0);
    check_rd({tag, "_result"}, exp_res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    add(0, A_N, 0, 1, 0, "rst_n_reg");
    add(0, A_G, 0, 1, 0, "rst_go");
    add(0, A_S, 0, 1, 0, "rst_status");
    add(0, A_R, 0, 1, 0, "rst_result");
    // 5! with busy window of exactly 5 cycles
    add(1, A_N, 5, 0, 0, "");
    add(1, A_G, 1, 0, 0, "");
    add_busy(5, "n5_busy");
    add(0, A_S, 0, 1, S_DONE, "n5_done");
    add(0, A_R, 0, 1, 32'h78, "n5_result");
    add(0, A_N, 0, 1, 5, "n5_nreg");
    // go with wd[0]=0 does nothing
    add(1, A_G, 2, 0, 0, "");
    add(0, A_S, 0, 1, S_DONE, "go_bit0_zero");
    // 0! and 1!
    add(1, A_N, 0, 0, 0, "");
    add(1, A_G, 1, 0, 0, "");
    add_busy(1, "n0_busy");
    add(0, A_S, 0, 1, S_DONE, "n0_done");
    add(0, A_R, 0, 1, 1, "n0_result");
    add(1, A_N, 1, 0, 0, "");
    add(1, A_G, 1, 0, 0, "");
    add_busy(1, "n1_busy");
    add(0, A_S, 0, 1, S_DONE, "n1_done");
    add(0, A_R, 0, 1, 1, "n1_result");
    // 12! is the largest that fits
    add(1, A_N, 12, 0, 0, "");
    add(1, A_G, 1, 0, 0, "");
    add_busy(12, "n12_busy");
    add(0, A_S, 0, 1, S_DONE, "n12_done");
    add(0, A_R, 0, 1, 32'h1C8CFC00, "n12_result");
    // 13 overflows: error on the go edge
    add(1, A_N, 13, 0, 0, "");
    add(1, A_G, 1, 0, 0, "");
    add(0, A_S, 0, 1, S_ERR, "n13_err");
    add(0, A_R, 0, 1, 0, "n13_result");
    // recovery clears err
    add(1, A_N, 2, 0, 0, "");
    add(1, A_G, 1, 0, 0, "");
    add_busy(2, "n2_busy");
    add(0, A_S, 0, 1, S_DONE, "n2_done");
    add(0, A_R, 0, 1, 2, "n2_result");
    // writes while busy are ignored
    add(1, A_N, 6, 0, 0, "");
    add(1, A_G, 1, 0, 0, "");
    add_busy(1, "n6_busy");
    add(1, A_N, 3, 1, 6, "n6_wr_n_busy");
    add(1, A_G, 1, 0, 0, "");
    add(0, A_N, 0, 1, 6, "n6_nreg_kept");
    add_busy(2, "n6_busy_late");
    add(0, A_S, 0, 1, S_DONE, "n6_done");
    add(0, A_R, 0, 1, 720, "n6_result");

    we    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("in_reset_rd", rd, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].a, tbl[i].wd);
      if (tbl[i].chk) check_rd(tbl[i].tag, tbl[i].exp);
    end

    // reset in the middle of a 7! run
    step(1, A_N, 7);
    step(1, A_G, 1);
    step(0, A_S, 0);
    check_rd("n7_busy1", S_BUSY);
    step(0, A_S, 0);
    step(0, A_S, 0);
    check_rd("n7_busy3", S_BUSY);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      #1;
      check($sformatf("abort_rd_a%0d", i), rd, 0);
    end
`ifdef FACT_ACCEL_IRQ_EN
    check("abort_irq", W'(irq), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(0, A_N, 0);
    check("post_abort_nreg", rd, 0);
    step(0, A_R, 0);
    check("post_abort_result", rd, 0);
    run_poll(4, 4, 24, "n4");
    run_poll(3, 3, 6, "n3");

`ifdef FACT_ACCEL_IRQ_EN
    step(1, A_S, 0);
    step(0, A_S, 0);
    check("irq_ack", rd, S_DONE);
    step(1, A_N, 3);
    step(1, A_G, 1);
    for (int i = 1; i <= 6; i++) begin
      step(0, A_S, 0);
      check($sformatf("irq_c%0d", i), W'(irq), W'(i == 4));
      if (i == 4) check("irq_status", rd, 32'h9);
    end
    check("irq_pend_hold", rd, 32'h9);
    step(1, A_S, 5);
    step(0, A_S, 0);
    check("irq_pend_clr", rd, S_DONE);
    step(1, A_N, 13);
    step(1, A_G, 1);
    step(0, A_S, 0);
    check("irq_err", W'(irq), 1);
    check("irq_err_status", rd, 32'hB);
    step(0, A_S, 0);
    check("irq_err_low", W'(irq), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
